paddle_ai_ctl: RTL and testbench

//  Computer-opponent paddle controller: consumes ball position (xpos, ypos) from ball_ctl
//  and produces the paddle position rect_y_pos that ball_ctl reads for collision.
//  The paddle tracks the approaching ball with a reaction delay and a speed limit,
//  and returns to the home position while the ball moves away.

---
 rtl/paddle_ai_ctl_pkg.sv | 44 ++++
 rtl/paddle_ai_ctl_tick_gen.sv | 43 ++++
 rtl/paddle_ai_ctl.sv | 138 +++++++++++++
 tb/tb_paddle_ai_ctl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/paddle_ai_ctl_pkg.sv
// Shared geometry, state encoding and position-step helper for the AI paddle.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package paddle_ai_ctl_pkg;

  localparam int POS_W     = 11;
  localparam int SCREEN_H  = 768;
  localparam int PADDLE_H  = 100;
  localparam int BALL_SIZE = 16;

  // Paddle rests centred on screen; Y_MAX keeps the whole paddle visible.
  localparam int HOME_Y = (SCREEN_H - PADDLE_H) / 2;
  localparam int Y_MAX  = SCREEN_H - PADDLE_H;

  typedef enum logic [1:0] {
    HOME  = 2'd0,
    WAIT  = 2'd1,
    TRACK = 2'd2
  } ai_state_t;

  // One move step from pos toward goal. Both operands are inside [0, Y_MAX]
  // and a step never overshoots the goal, so the result stays in range.
  function automatic logic [POS_W-1:0] step_toward(
    input logic [POS_W-1:0]  pos,
    input logic [POS_W-1:0]  goal,
    input logic signed [12:0] spd,
    input logic signed [12:0] db
  );
    logic signed [12:0] p;
    logic signed [12:0] err;
    p   = $signed({2'b00, pos});
    err = $signed({2'b00, goal}) - p;
    if ((err <= db) && (err >= -db)) begin
      step_toward = pos;
    end else if (err > spd) begin
      step_toward = POS_W'(p + spd);
    end else if (err < -spd) begin
      step_toward = POS_W'(p - spd);
    end else begin
      step_toward = goal;
    end
  endfunction

endpackage

// File: rtl/paddle_ai_ctl_tick_gen.sv
// Free-running move-tick divider: tick is high for one clk every TICK_DIV clks.
// Latency: first tick TICK_DIV clks after reset release, then every TICK_DIV clks.
// Backpressure: none; runs unconditionally.
module paddle_ai_ctl_tick_gen #(
  parameter int TICK_DIV = 200_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;
  logic          tick_d;

  // Next count wraps at TICK_DIV-1; the pulse is registered on the wrap.
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Counter and registered tick pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/paddle_ai_ctl.sv
// Computer-opponent paddle: follows an approaching ball after a hesitation, goes home otherwise.
// Latency: ball change acts on the next qualified move tick (<= TICK_DIV clk).
// Backpressure: none; en=0 freezes direction, FSM, delay and position.
module paddle_ai_ctl
  import paddle_ai_ctl_pkg::*;
#(
  parameter int REACT_X   = 512,
  parameter int REACT_DLY = 8,
  parameter int SPEED     = 2,
  parameter int DEADBAND  = 3,
  parameter int TICK_DIV  = 200_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [POS_W-1:0] xpos,
  input  logic [POS_W-1:0] ypos,
  output logic [POS_W-1:0] rect_y_pos,
  output logic             tracking
);

  localparam int DW = (REACT_DLY > 0) ? $clog2(REACT_DLY + 1) : 1;

  localparam logic [POS_W-1:0] HOME_YV  = POS_W'(HOME_Y);
  localparam logic [POS_W-1:0] Y_MAXV   = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] REACT_XV = POS_W'(REACT_X);
  localparam logic [DW-1:0]    DLY_INIT = DW'(REACT_DLY);
  localparam logic signed [12:0] SPD    = 13'(SPEED);
  localparam logic signed [12:0] DB     = 13'(DEADBAND);
  localparam logic signed [12:0] Y_MAXS = 13'(Y_MAX);
  // Paddle centre aligned with ball centre.
  localparam logic signed [12:0] TGT_OFS = 13'(BALL_SIZE / 2 - PADDLE_H / 2);

  logic             move_tick;
  logic             qual_tick;
  logic [POS_W-1:0] xpos_prev_q;
  logic             approaching;
  logic             receding;
  logic             exit_evt;
  logic signed [12:0] tgt_raw;
  logic [POS_W-1:0] tgt_clamped;
  logic [POS_W-1:0] home_step;
  logic [POS_W-1:0] track_step;

  ai_state_t        state_q;
  logic [POS_W-1:0] pos_q;
  logic [DW-1:0]    dly_q;
  logic             tracking_q;

  paddle_ai_ctl_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (move_tick)
  );

  assign qual_tick = move_tick & en;

  // Ball x from the previous qualified tick, used to tell direction of travel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos_prev_q <= '0;
    end else if (qual_tick) begin
      xpos_prev_q <= xpos;
    end
  end

  // Direction, clamped target and candidate steps; equal x keeps the current course.
  always_comb begin
    approaching = (xpos > xpos_prev_q);
    receding    = (xpos < xpos_prev_q);
    exit_evt    = receding || (xpos == '0);
    tgt_raw     = $signed({2'b00, ypos}) + TGT_OFS;
    if (tgt_raw[12]) begin
      tgt_clamped = '0;
    end else if (tgt_raw > Y_MAXS) begin
      tgt_clamped = Y_MAXV;
    end else begin
      tgt_clamped = tgt_raw[POS_W-1:0];
    end
    home_step  = step_toward(pos_q, HOME_YV, SPD, DB);
    track_step = step_toward(pos_q, tgt_clamped, SPD, DB);
  end

  // FSM, hesitation counter and paddle position; each state moves by its own rule
  // in the tick it transitions, and a ball exit beats delay expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOME;
      pos_q      <= HOME_YV;
      dly_q      <= '0;
      tracking_q <= 1'b0;
    end else if (qual_tick) begin
      case (state_q)
        HOME: begin
          pos_q <= home_step;
          if (approaching && (xpos >= REACT_XV)) begin
            state_q <= WAIT;
            dly_q   <= DLY_INIT;
          end
          tracking_q <= 1'b0;
        end
        WAIT: begin
          if (dly_q != '0) begin
            dly_q <= dly_q - DW'(1);
          end
          if (exit_evt) begin
            state_q    <= HOME;
            tracking_q <= 1'b0;
          end else if (dly_q <= DW'(1)) begin
            state_q    <= TRACK;
            tracking_q <= 1'b1;
          end else begin
            tracking_q <= 1'b0;
          end
        end
        TRACK: begin
          pos_q <= track_step;
          if (exit_evt) begin
            state_q    <= HOME;
            tracking_q <= 1'b0;
          end else begin
            tracking_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= HOME;
          tracking_q <= 1'b0;
        end
      endcase
    end
  end

  assign rect_y_pos = pos_q;
  assign tracking   = tracking_q;

endmodule

// File: tb/tb_paddle_ai_ctl.sv
// Directed bench for paddle_ai_ctl with a reference model feeding a scoreboard.
// Latency: outputs sampled two half-cycles-plus after each move-tick edge.
// Backpressure: n/a.
module tb_paddle_ai_ctl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic [10:0] rect_y_pos;
  logic        tracking;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int    pos;
    int    trk;
    string tag;
  } exp_t;
  exp_t sb[$];

  int m_state;
  int m_dly;
  int m_pos;
  int m_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  paddle_ai_ctl #(
    .TICK_DIV  (4),
    .REACT_DLY (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .xpos       (xpos),
    .ypos       (ypos),
    .rect_y_pos (rect_y_pos),
    .tracking   (tracking)
  );

  // Clock edges since reset release; the tick counter in the DUT restarts with it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int step_m(input int p, input int g);
    int e;
    e = g - p;
    if (e <= 3 && e >= -3) return p;
    if (e > 2) return p + 2;
    if (e < -2) return p - 2;
    return g;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_dly   = 0;
    m_pos   = 334;
    m_prev  = 0;
  endtask

  // Behavioural reference: HOME=0, WAIT=1, TRACK=2.
  task automatic model_tick(input int x, input int y, input bit e);
    int t;
    bit ap;
    bit rc;
    if (!e) return;
    ap = (x > m_prev);
    rc = (x < m_prev);
    t  = y + 8 - 50;
    if (t < 0)   t = 0;
    if (t > 668) t = 668;
    case (m_state)
      0: begin
        m_pos = step_m(m_pos, 334);
        if (ap && x >= 512) begin
          m_state = 1;
          m_dly   = 3;
        end
      end
      1: begin
        if (rc || x == 0)   m_state = 0;
        else if (m_dly == 1) m_state = 2;
        m_dly = m_dly - 1;
      end
      default: begin
        m_pos = step_m(m_pos, t);
        if (rc || x == 0) m_state = 0;
      end
    endcase
    m_prev = x;
  endtask

  // Drive one tick's inputs at a negedge, predict, wait out the tick, compare.
  task automatic tick_step(input int x, input int y, input bit e, input string tag);
    exp_t ex;
    xpos = 11'(x);
    ypos = 11'(y);
    en   = e;
    model_tick(x, y, e);
    sb.push_back('{m_pos, (m_state == 2) ? 1 : 0, tag});
    for (int i = 0; i < 8 && !((cyc % 4) == 0 && cyc >= 4); i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    ex = sb.pop_front();
    check({ex.tag, ".pos"}, 32'(rect_y_pos), 32'(ex.pos));
    check({ex.tag, ".trk"}, 32'(tracking), 32'(ex.trk));
  endtask

  task automatic run_ticks(input int n, input int x, input int y, input string tag);
    for (int i = 0; i < n; i++) tick_step(x, y, 1'b1, tag);
  endtask

  // Ramp x from 500 to 520 then hold, which enters WAIT at 512 and TRACK three ticks later.
  task automatic approach(input int y, input string tag);
    for (int x = 500; x <= 520; x += 4) tick_step(x, y, 1'b1, tag);
    run_ticks(2, 520, y, tag);
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    xpos  = '0;
    ypos  = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset.pos", 32'(rect_y_pos), 32'd334);
    check("reset.trk", 32'(tracking), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Approach toward ypos=100: WAIT at 334, then descend 2/tick to the deadband of 58.
    approach(100, "approach");
    run_ticks(145, 520, 100, "approach");
    check("approach.deadband", 32'((rect_y_pos >= 11'd55) && (rect_y_pos <= 11'd61)), 32'd1);

    // Low ball target clamps at Y_MAX.
    run_ticks(310, 520, 760, "clamp_hi");
    check("clamp_hi.range", 32'((rect_y_pos >= 11'd665) && (rect_y_pos <= 11'd668)), 32'd1);

    // Settle at 600 while tracking, then reset mid-TRACK.
    run_ticks(40, 520, 640, "to600");
    check("to600.pos", 32'(rect_y_pos), 32'd600);
    rst_n = 1'b0;
    #1;
    check("midreset.pos", 32'(rect_y_pos), 32'd334);
    check("midreset.trk", 32'(tracking), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Top-of-screen target clamps at 0 with no wrap.
    approach(0, "clamp_lo");
    run_ticks(175, 520, 0, "clamp_lo");
    check("clamp_lo.range", 32'(rect_y_pos <= 11'd3), 32'd1);

    // Move to 200, then the ball recedes: HOME, climb back toward 334.
    run_ticks(105, 520, 244, "to200");
    check("to200.pos", 32'(rect_y_pos), 32'd200);
    tick_step(516, 244, 1'b1, "recede");
    check("recede.trk", 32'(tracking), 32'd0);
    run_ticks(75, 516, 244, "home");
    check("home.range", 32'((rect_y_pos >= 11'd331) && (rect_y_pos <= 11'd337)), 32'd1);

    // Miss: x jumps to 0 while tracking.
    approach(244, "miss_in");
    run_ticks(3, 520, 244, "miss_in");
    tick_step(0, 244, 1'b1, "miss");
    run_ticks(2, 0, 244, "miss_after");

    // Recede in the same tick the hesitation expires: HOME wins.
    tick_step(508, 244, 1'b1, "wexp");
    tick_step(512, 244, 1'b1, "wexp");
    tick_step(516, 244, 1'b1, "wexp");
    tick_step(520, 244, 1'b1, "wexp");
    tick_step(516, 244, 1'b1, "wexp_recede");
    run_ticks(3, 516, 244, "wexp_after");

    // Freeze in WAIT with two ticks of hesitation left; a receding x must be ignored.
    tick_step(520, 244, 1'b1, "frz_in");
    tick_step(524, 244, 1'b1, "frz_in");
    en   = 1'b0;
    xpos = 11'd100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("freeze.pos", 32'(rect_y_pos), 32'(m_pos));
      check("freeze.trk", 32'(tracking), 32'd0);
    end
    tick_step(524, 244, 1'b1, "resume1");
    tick_step(524, 244, 1'b1, "resume2");
    check("resume.trk", 32'(tracking), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
